fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit with NORMAL/SWI/EXC/HWI address regions,
// handler entry/return redirects, jumps and a valid/ready instr register.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   addr / data       fetch address {mode, pc} and same-cycle read data
//   instr             fetched instruction, with instr_valid / instr_ready
//   jump_en           in-region jump to jump_target
//   jump_target       jump destination pc
//   swi_req           software-interrupt request
//   exc_req           exception request
//   hwi_req           hardware-interrupt request
//   ret               return from handler to NORMAL
//   mode              current region
package fetch_pkg;
    typedef struct packed {
        logic [5:0] phys_addr;
    } addr_t;

    typedef struct packed {
        logic [7:0] raw_data;
    } data_t;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        SWI    = 2'b01,
        EXC    = 2'b10,
        HWI    = 2'b11
    } mode_e;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    output addr_t      addr,
    input  data_t      data,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       jump_en,
    input  logic [3:0] jump_target,
    input  logic       swi_req,
    input  logic       exc_req,
    input  logic       hwi_req,
    input  logic       ret,
    output logic [1:0] mode
);

    mode_e      mode_q, mode_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] spc_q, spc_d;
    logic [7:0] instr_q, instr_d;
    logic       vld_q, vld_d;

    logic take_exc, take_hwi, take_swi;
    logic take_ret, take_jmp;
    logic entry;

    // Each take_* is already masked by every higher-priority event,
    // so at most one is set and the case below is truly unique.
    always_comb begin
        take_exc = exc_req && (mode_q != EXC);
        take_hwi = hwi_req && (mode_q == NORMAL)
                   && !take_exc;
        take_swi = swi_req && (mode_q == NORMAL)
                   && !take_exc && !take_hwi;
        entry    = take_exc || take_hwi || take_swi;
        take_ret = ret && (mode_q != NORMAL) && !entry;
        take_jmp = jump_en && !entry && !take_ret;
    end

    always_comb begin
        mode_d  = mode_q;
        pc_d    = pc_q;
        spc_d   = spc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        unique case (1'b1)
            entry: begin
                unique case (1'b1)
                    take_exc: mode_d = EXC;
                    take_hwi: mode_d = HWI;
                    default:  mode_d = SWI;
                endcase
                pc_d  = 4'h0;
                vld_d = 1'b0;
                // Nested entry into EXC keeps the NORMAL return point.
                if (mode_q == NORMAL) spc_d = pc_q;
            end
            take_ret: begin
                mode_d = NORMAL;
                pc_d   = spc_q;
                vld_d  = 1'b0;
            end
            take_jmp: begin
                pc_d  = jump_target;
                vld_d = 1'b0;
            end
            default: begin
                if (!vld_q || instr_ready) begin
                    instr_d = data.raw_data;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + 4'h1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= NORMAL;
            pc_q    <= RESET_PC;
            spc_q   <= 4'h0;
            instr_q <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pc_q    <= pc_d;
            spc_q   <= spc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign addr.phys_addr = {mode_q, pc_q};
    assign instr          = instr_q;
    assign instr_valid    = vld_q;
    assign mode           = mode_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirect/stall/reset
// sequences, expected instrs queued and checked on consumption.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    addr_t      addr;
    data_t      data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [3:0] jump_target;
    logic       swi_req;
    logic       exc_req;
    logic       hwi_req;
    logic       ret;
    logic [1:0] mode;

    int npass = 0;
    int ntot  = 0;
    logic [7:0] expq[$];

    fetch_unit #(.RESET_PC(4'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .data(data),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_en(jump_en),
        .jump_target(jump_target),
        .swi_req(swi_req),
        .exc_req(exc_req),
        .hwi_req(hwi_req),
        .ret(ret),
        .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [5:0] a);
        return {a, 2'b00} ^ 8'h5A;
    endfunction

    assign data = data_t'(memf(addr.phys_addr));

    task automatic chk(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string name,
                          input logic [1:0] m,
                          input logic [5:0] a,
                          input logic v);
        chk({name, ".mode"}, {6'd0, mode}, {6'd0, m});
        chk({name, ".addr"}, {2'd0, addr.phys_addr}, {2'd0, a});
        chk({name, ".valid"}, {7'd0, instr_valid}, {7'd0, v});
    endtask

    // Monitor: every instr seen while consumed must match the queue head.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
                ntot++;
                $display("FAIL sb_empty: got %h want none", instr);
            end else begin
                chk("sb_instr", instr, expq.pop_front());
            end
        end
    end

    initial begin
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        jump_target = 4'h0;
        swi_req     = 1'b0;
        exc_req     = 1'b0;
        hwi_req     = 1'b0;
        ret         = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_st("rst0", 2'd0, 6'h00, 1'b0);
        chk("rst0.instr", instr, 8'h00);
        @(posedge clk);
        #1;
        chk_st("rst1", 2'd0, 6'h00, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Streaming with wrap inside NORMAL
        for (int i = 0; i < 17; i++) begin
            expq.push_back(memf({2'b00, 4'(i)}));
            cyc();
            chk_st("stream", 2'd0, {2'b00, 4'(i + 1)}, 1'b1);
        end
        for (int i = 1; i < 5; i++) begin
            expq.push_back(memf({2'b00, 4'(i)}));
            cyc();
        end
        chk("pre_stall.addr", {2'd0, addr.phys_addr}, 8'h05);

        // Stall
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_st("stall", 2'd0, 6'h05, 1'b1);
            chk("stall.instr", instr, memf(6'h04));
        end
        instr_ready = 1'b1;
        expq.push_back(memf(6'h05));
        cyc();
        chk("unstall.addr", {2'd0, addr.phys_addr}, 8'h06);
        expq.push_back(memf(6'h06));
        cyc();

        // SWI round trip from pc 7
        swi_req = 1'b1;
        cyc();
        swi_req = 1'b0;
        chk_st("swi", 2'd1, 6'h10, 1'b0);
        expq.push_back(memf(6'h10));
        cyc();
        chk_st("swi_f1", 2'd1, 6'h11, 1'b1);
        expq.push_back(memf(6'h11));
        cyc();
        ret = 1'b1;
        cyc();
        ret = 1'b0;
        chk_st("swi_ret", 2'd0, 6'h07, 1'b0);
        expq.push_back(memf(6'h07));
        cyc();
        chk_st("after_ret", 2'd0, 6'h08, 1'b1);

        // Priority: all three requests in NORMAL
        exc_req = 1'b1;
        hwi_req = 1'b1;
        swi_req = 1'b1;
        cyc();
        exc_req = 1'b0;
        hwi_req = 1'b0;
        swi_req = 1'b0;
        chk_st("prio", 2'd2, 6'h20, 1'b0);
        ret = 1'b1;
        cyc();
        ret = 1'b0;
        chk_st("prio_ret", 2'd0, 6'h08, 1'b0);

        // HWI, then nested EXC keeps saved pc
        hwi_req = 1'b1;
        cyc();
        hwi_req = 1'b0;
        chk_st("hwi", 2'd3, 6'h30, 1'b0);
        expq.push_back(memf(6'h30));
        cyc();
        expq.push_back(memf(6'h31));
        cyc();
        exc_req = 1'b1;
        cyc();
        exc_req = 1'b0;
        chk_st("nest_exc", 2'd2, 6'h20, 1'b0);
        swi_req = 1'b1;
        expq.push_back(memf(6'h20));
        cyc();
        swi_req = 1'b0;
        chk_st("swi_in_exc", 2'd2, 6'h21, 1'b1);
        ret = 1'b1;
        cyc();
        ret = 1'b0;
        chk_st("exc_ret", 2'd0, 6'h08, 1'b0);

        // Jump versus entry
        jump_en     = 1'b1;
        jump_target = 4'hC;
        hwi_req     = 1'b1;
        cyc();
        jump_en = 1'b0;
        hwi_req = 1'b0;
        chk_st("jmp_vs_hwi", 2'd3, 6'h30, 1'b0);
        expq.push_back(memf(6'h30));
        cyc();
        jump_en = 1'b1;
        cyc();
        jump_en = 1'b0;
        chk_st("jmp_hwi", 2'd3, 6'h3C, 1'b0);
        expq.push_back(memf(6'h3C));
        cyc();
        chk_st("jmp_fetch", 2'd3, 6'h3D, 1'b1);
        ret = 1'b1;
        cyc();
        ret = 1'b0;
        chk_st("hwi_ret", 2'd0, 6'h08, 1'b0);

        // Async reset while in SWI
        swi_req = 1'b1;
        cyc();
        swi_req = 1'b0;
        chk_st("swi2", 2'd1, 6'h10, 1'b0);
        expq.push_back(memf(6'h10));
        cyc();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_st("arst", 2'd0, 6'h00, 1'b0);
        chk("arst.instr", instr, 8'h00);
        @(posedge clk);
        #1;
        chk_st("arst_hold", 2'd0, 6'h00, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        expq.push_back(memf(6'h00));
        cyc();
        chk_st("post_rst", 2'd0, 6'h01, 1'b1);
        @(negedge clk);
        #1;
        chk("sb_drain", 8'(expq.size()), 8'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
